kb_matrix_scan: RTL and testbench

- Scans a 4x4 mechanical key matrix. Drives one row low at a time and samples the four column returns.
- Debounces the pressed key and emits a one-cycle key_valid pulse with the 4-bit key code.
- It is the input-side counterpart of the row-scanned 8x8 dot-matrix display driver. Its key_code/key_valid pair feeds the digit counter that drives the display's num input.

---
 rtl/kb_pkg.sv | 40 ++++
 rtl/kb_sync2.sv | 36 +++
 rtl/kb_matrix_scan.sv | 184 ++++++++++++++++++
 tb/tb_kb_matrix_scan.sv | 283 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/kb_pkg.sv
// kb_pkg: shared definitions for the 4x4 key matrix scanner.
//   - kb_state_e : scanner FSM state encoding
//   - KB_ROWS / KB_COLS : matrix geometry
//   - ROW_INIT : row drive pattern after reset (row 0 driven low)
//   - kb_one_low / kb_low_idx : helpers for active-low one-hot vectors
package kb_pkg;

    typedef enum logic [1:0] {
        SCAN     = 2'd0,
        DEBOUNCE = 2'd1,
        HELD     = 2'd2
    } kb_state_e;

    localparam int KB_ROWS = 4;
    localparam int KB_COLS = 4;

    localparam logic [KB_ROWS-1:0] ROW_INIT = 4'b1110;

    // True when exactly one bit of v is 0. No low bits (idle) and several
    // low bits (ghosting / multi-key) are both rejected.
    function automatic logic kb_one_low(input logic [3:0] v);
        int zeros;
        zeros = 0;
        for (int i = 0; i < 4; i++) begin
            if (!v[i]) zeros++;
        end
        return (zeros == 1);
    endfunction

    // Index of the 0 bit; only meaningful when kb_one_low(v) is true.
    function automatic logic [1:0] kb_low_idx(input logic [3:0] v);
        logic [1:0] idx;
        idx = 2'd0;
        for (int i = 0; i < 4; i++) begin
            if (!v[i]) idx = 2'(i);
        end
        return idx;
    endfunction

endpackage

// File: rtl/kb_sync2.sv
// kb_sync2: two-flop synchronizer for asynchronous level inputs.
//   clk   : destination clock
//   rst   : asynchronous reset, active-high; both stages reset to all 1s
//           (the idle level of the pulled-up column lines)
//   d     : asynchronous input vector
//   q     : synchronized output, two clk cycles behind d
module kb_sync2 #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] s1_q, s1_d;
    logic [WIDTH-1:0] s2_q, s2_d;

    always_comb begin
        s1_d = d;
        s2_d = s1_q;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_q <= '1;
            s2_q <= '1;
        end else begin
            s1_q <= s1_d;
            s2_q <= s2_d;
        end
    end

    assign q = s2_q;

endmodule

// File: rtl/kb_matrix_scan.sv
// kb_matrix_scan: 4x4 key matrix scanner with debounce.
//   clk       : system clock
//   rst       : asynchronous reset, active-high
//   kb_col    : column returns (pulled up, low = closed key in driven row)
//   kb_row    : row drive, active-low, exactly one row low at a time
//   key_code  : row*4 + col of the last confirmed key
//   key_valid : one-cycle pulse, coincident with the new key_code
//   key_held  : high from press confirmation until release confirmation
//   dbg_state : current scanner FSM state
//
// Handshake: key_valid is a one-cycle strobe with no ready/back-pressure;
// key_code is stable from the key_valid cycle until the next confirmation.
//
// All FSM decisions happen only on tick cycles (once every SCAN_DIV clocks),
// so each driven row settles for SCAN_DIV-1 cycles, which covers the
// synchronizer latency before its columns are sampled.
module kb_matrix_scan
    import kb_pkg::*;
#(
    parameter int SCAN_DIV       = 50000,
    parameter int DEBOUNCE_TICKS = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [KB_COLS-1:0] kb_col,
    output logic [KB_ROWS-1:0] kb_row,
    output logic [3:0]         key_code,
    output logic               key_valid,
    output logic               key_held,
    output kb_state_e          dbg_state
);

    localparam int CW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int DW = $clog2(DEBOUNCE_TICKS + 1);

    localparam logic [CW-1:0] TICK_LAST = CW'(SCAN_DIV - 1);
    localparam logic [DW-1:0] DEB_LAST  = DW'(DEBOUNCE_TICKS);

    logic [KB_COLS-1:0] col_s;

    kb_sync2 #(.WIDTH(KB_COLS)) u_col_sync (
        .clk (clk),
        .rst (rst),
        .d   (kb_col),
        .q   (col_s)
    );

    kb_state_e          state_q, state_d;
    logic [CW-1:0]      cnt_q, cnt_d;
    logic [DW-1:0]      deb_q, deb_d;
    logic [KB_ROWS-1:0] row_q, row_d;
    logic [1:0]         cand_row_q, cand_row_d;
    logic [1:0]         cand_col_q, cand_col_d;
    logic [3:0]         code_q, code_d;
    logic               valid_q, valid_d;
    logic               held_q, held_d;

    logic               tick;
    logic               col_ok;
    logic [1:0]         col_idx;
    logic [1:0]         row_idx;
    logic [KB_ROWS-1:0] row_next;
    logic [DW-1:0]      deb_inc;

    always_comb begin
        tick     = (cnt_q == TICK_LAST);
        col_ok   = kb_one_low(col_s);
        col_idx  = kb_low_idx(col_s);
        row_idx  = kb_low_idx(row_q);
        row_next = {row_q[KB_ROWS-2:0], row_q[KB_ROWS-1]};
        deb_inc  = deb_q + DW'(1);
    end

    always_comb begin
        state_d    = state_q;
        cnt_d      = tick ? '0 : cnt_q + CW'(1);
        deb_d      = deb_q;
        row_d      = row_q;
        cand_row_d = cand_row_q;
        cand_col_d = cand_col_q;
        code_d     = code_q;
        valid_d    = 1'b0;
        held_d     = held_q;

        case (state_q)
            SCAN: begin
                if (tick) begin
                    if (col_ok) begin
                        cand_row_d = row_idx;
                        cand_col_d = col_idx;
                        if (DEBOUNCE_TICKS == 1) begin
                            code_d  = {row_idx, col_idx};
                            valid_d = 1'b1;
                            held_d  = 1'b1;
                            deb_d   = '0;
                            state_d = HELD;
                        end else begin
                            deb_d   = DW'(1);
                            state_d = DEBOUNCE;
                        end
                    end else begin
                        row_d = row_next;
                    end
                end
            end

            DEBOUNCE: begin
                if (tick) begin
                    if (col_ok && (col_idx == cand_col_q)) begin
                        if (deb_inc == DEB_LAST) begin
                            code_d  = {cand_row_q, cand_col_q};
                            valid_d = 1'b1;
                            held_d  = 1'b1;
                            deb_d   = '0;
                            state_d = HELD;
                        end else begin
                            deb_d = deb_inc;
                        end
                    end else begin
                        // Bounce or key moved: abandon the candidate.
                        deb_d   = '0;
                        row_d   = row_next;
                        state_d = SCAN;
                    end
                end
            end

            HELD: begin
                // Row stays frozen; only a clean all-open reading counts
                // toward release, anything else restarts the release count.
                if (tick) begin
                    if (col_s == 4'b1111) begin
                        if (deb_inc == DEB_LAST) begin
                            held_d  = 1'b0;
                            deb_d   = '0;
                            row_d   = row_next;
                            state_d = SCAN;
                        end else begin
                            deb_d = deb_inc;
                        end
                    end else begin
                        deb_d = '0;
                    end
                end
            end

            default: begin
                deb_d   = '0;
                state_d = SCAN;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= SCAN;
            cnt_q      <= '0;
            deb_q      <= '0;
            row_q      <= ROW_INIT;
            cand_row_q <= '0;
            cand_col_q <= '0;
            code_q     <= '0;
            valid_q    <= 1'b0;
            held_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            deb_q      <= deb_d;
            row_q      <= row_d;
            cand_row_q <= cand_row_d;
            cand_col_q <= cand_col_d;
            code_q     <= code_d;
            valid_q    <= valid_d;
            held_q     <= held_d;
        end
    end

    assign kb_row    = row_q;
    assign key_code  = code_q;
    assign key_valid = valid_q;
    assign key_held  = held_q;
    assign dbg_state = state_q;

endmodule

// File: tb/tb_kb_matrix_scan.sv
// tb_kb_matrix_scan: directed bench for kb_matrix_scan with SCAN_DIV=4,
// DEBOUNCE_TICKS=3. A small key-matrix model turns the "keys" mask
// (bit r*4+c = key at row r, column c closed) into column returns for the
// currently driven row.
module tb_kb_matrix_scan;
    import kb_pkg::*;

    logic       clk;
    logic       rst;
    logic [3:0] kb_col;
    logic [3:0] kb_row;
    logic [3:0] key_code;
    logic       key_valid;
    logic       key_held;
    kb_state_e  dbg_state;

    logic [15:0] keys;

    int checks;
    int errors;
    int pulse_cnt;
    int exp_pulses;
    bit double_pulse;
    bit prev_valid;

    kb_matrix_scan #(
        .SCAN_DIV       (4),
        .DEBOUNCE_TICKS (3)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .kb_col    (kb_col),
        .kb_row    (kb_row),
        .key_code  (key_code),
        .key_valid (key_valid),
        .key_held  (key_held),
        .dbg_state (dbg_state)
    );

    // Clock / reset
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Key matrix model
    always_comb begin
        kb_col = 4'b1111;
        for (int r = 0; r < 4; r++) begin
            if (kb_row[r] == 1'b0) begin
                for (int c = 0; c < 4; c++) begin
                    if (keys[r*4+c]) kb_col[c] = 1'b0;
                end
            end
        end
    end

    // Pulse monitor
    always @(negedge clk) begin
        if (rst) begin
            prev_valid = 1'b0;
        end else begin
            if (key_valid === 1'b1) begin
                pulse_cnt++;
                if (prev_valid) double_pulse = 1'b1;
            end
            prev_valid = (key_valid === 1'b1);
        end
    end

    // Driver / wait tasks
    task automatic wait_row(input logic [3:0] row, input int budget, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (kb_row === row) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic wait_pulse(input int budget, output int cycles, output bit ok);
        ok = 1'b0;
        cycles = 0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            cycles++;
            if (key_valid === 1'b1) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic wait_held_low(input int budget, output int cycles, output bit ok);
        ok = 1'b0;
        cycles = 0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            cycles++;
            if (key_held === 1'b0) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    // Tests
    task automatic test_reset();
        logic [3:0] exp_row;
        rst  = 1'b1;
        keys = 16'h0000;
        repeat (2) @(negedge clk);
        checks++; if (kb_row !== 4'b1110) begin errors++; $display("FAIL reset_row: got %b want 1110", kb_row); end
        checks++; if (key_code !== 4'd0) begin errors++; $display("FAIL reset_code: got %0d want 0", key_code); end
        checks++; if (key_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b want 0", key_valid); end
        checks++; if (key_held !== 1'b0) begin errors++; $display("FAIL reset_held: got %b want 0", key_held); end
        checks++; if (dbg_state !== SCAN) begin errors++; $display("FAIL reset_state: got %0d want 0", dbg_state); end
        rst = 1'b0;
        for (int i = 1; i <= 16; i++) begin
            @(negedge clk);
            exp_row = 4'b1110;
            for (int k = 0; k < (i / 4) % 4; k++) exp_row = {exp_row[2:0], exp_row[3]};
            checks++;
            if (kb_row !== exp_row || key_valid !== 1'b0) begin
                errors++;
                $display("FAIL idle_scan cycle %0d: row %b valid %b want row %b valid 0", i, kb_row, key_valid, exp_row);
            end
        end
    endtask

    task automatic test_press();
        bit ok;
        int cyc;
        wait_row(4'b1101, 20, ok);
        keys = 16'h0200;  // r2,c1
        wait_row(4'b1011, 20, ok);
        checks++; if (!ok) begin errors++; $display("FAIL press_reach_row: row %b want 1011", kb_row); end
        wait_pulse(40, cyc, ok);
        exp_pulses++;
        checks++; if (!ok) begin errors++; $display("FAIL press_pulse: no key_valid within 40 cycles"); end
        checks++; if (cyc != 12) begin errors++; $display("FAIL press_latency: got %0d cycles want 12", cyc); end
        checks++; if (key_code !== 4'd9) begin errors++; $display("FAIL press_code: got %0d want 9", key_code); end
        checks++; if (key_held !== 1'b1) begin errors++; $display("FAIL press_held: got %b want 1", key_held); end
        checks++; if (kb_row !== 4'b1011) begin errors++; $display("FAIL press_row_frozen: got %b want 1011", kb_row); end
        checks++; if (dbg_state !== HELD) begin errors++; $display("FAIL press_state: got %0d want 2", dbg_state); end
        @(negedge clk);
        checks++; if (key_valid !== 1'b0) begin errors++; $display("FAIL press_one_cycle: valid %b want 0", key_valid); end
    endtask

    task automatic test_release();
        bit ok;
        int cyc;
        keys = 16'h0000;
        wait_held_low(30, cyc, ok);
        checks++; if (!ok) begin errors++; $display("FAIL release_held: key_held still %b", key_held); end
        checks++; if (cyc != 11) begin errors++; $display("FAIL release_latency: got %0d cycles want 11", cyc); end
        checks++; if (kb_row !== 4'b0111) begin errors++; $display("FAIL release_row: got %b want 0111", kb_row); end
        checks++; if (dbg_state !== SCAN) begin errors++; $display("FAIL release_state: got %0d want 0", dbg_state); end
        checks++; if (key_code !== 4'd9) begin errors++; $display("FAIL release_code_kept: got %0d want 9", key_code); end
        repeat (8) @(negedge clk);
        checks++; if (pulse_cnt != exp_pulses) begin errors++; $display("FAIL release_no_pulse: pulses %0d want %0d", pulse_cnt, exp_pulses); end
    endtask

    task automatic test_bounce();
        bit ok;
        int cyc;
        wait_row(4'b0111, 20, ok);
        keys = 16'h0008;  // r0,c3
        wait_row(4'b1110, 20, ok);
        repeat (4) @(negedge clk);
        checks++; if (dbg_state !== DEBOUNCE) begin errors++; $display("FAIL bounce_in_debounce: state %0d want 1", dbg_state); end
        keys = 16'h0000;
        wait_row(4'b1101, 12, ok);
        checks++; if (!ok) begin errors++; $display("FAIL bounce_resume: row %b want 1101", kb_row); end
        checks++; if (dbg_state !== SCAN || key_held !== 1'b0) begin errors++; $display("FAIL bounce_state: state %0d held %b want 0/0", dbg_state, key_held); end
        checks++; if (pulse_cnt != exp_pulses) begin errors++; $display("FAIL bounce_no_pulse: pulses %0d want %0d", pulse_cnt, exp_pulses); end
        wait_row(4'b0111, 20, ok);
        keys = 16'h0008;
        wait_pulse(60, cyc, ok);
        exp_pulses++;
        checks++; if (!ok) begin errors++; $display("FAIL bounce_stable_pulse: no key_valid"); end
        checks++; if (key_code !== 4'd3) begin errors++; $display("FAIL bounce_stable_code: got %0d want 3", key_code); end
        keys = 16'h0000;
        wait_held_low(40, cyc, ok);
        checks++; if (!ok) begin errors++; $display("FAIL bounce_release: key_held still %b", key_held); end
    endtask

    task automatic test_multikey();
        bit ok;
        int cyc;
        wait_row(4'b1110, 20, ok);
        keys = 16'h0030;  // r1,c0 and r1,c1 -> kb_col=1100 on row 1
        wait_row(4'b1101, 20, ok);
        wait_row(4'b1011, 20, ok);
        checks++; if (!ok) begin errors++; $display("FAIL multi_scan_past: row %b want 1011", kb_row); end
        checks++; if (dbg_state !== SCAN || key_held !== 1'b0) begin errors++; $display("FAIL multi_state: state %0d held %b want 0/0", dbg_state, key_held); end
        wait_row(4'b1101, 20, ok);
        wait_row(4'b1011, 20, ok);
        checks++; if (pulse_cnt != exp_pulses) begin errors++; $display("FAIL multi_no_pulse: pulses %0d want %0d", pulse_cnt, exp_pulses); end

        keys = 16'h0000;
        wait_row(4'b0111, 20, ok);
        keys = 16'h0001;  // r0,c0
        wait_pulse(60, cyc, ok);
        exp_pulses++;
        checks++; if (!ok || key_code !== 4'd0) begin errors++; $display("FAIL held_first_key: ok %0d code %0d want 1/0", ok, key_code); end
        keys = 16'h0003;  // add r0,c1: multi-key while held
        repeat (12) @(negedge clk);
        keys = 16'h0002;  // only the other key remains
        repeat (20) @(negedge clk);
        checks++; if (key_held !== 1'b1 || dbg_state !== HELD) begin errors++; $display("FAIL held_ignore_state: held %b state %0d want 1/2", key_held, dbg_state); end
        checks++; if (kb_row !== 4'b1110 || key_code !== 4'd0) begin errors++; $display("FAIL held_ignore_out: row %b code %0d want 1110/0", kb_row, key_code); end
        checks++; if (pulse_cnt != exp_pulses) begin errors++; $display("FAIL held_ignore_pulse: pulses %0d want %0d", pulse_cnt, exp_pulses); end
        keys = 16'h0000;
        wait_held_low(40, cyc, ok);
        checks++; if (!ok || kb_row !== 4'b1101) begin errors++; $display("FAIL held_full_release: ok %0d row %b want 1/1101", ok, kb_row); end
        checks++; if (pulse_cnt != exp_pulses) begin errors++; $display("FAIL held_release_pulse: pulses %0d want %0d", pulse_cnt, exp_pulses); end
    endtask

    task automatic test_reset_mid();
        bit ok;
        int cyc;
        wait_row(4'b1101, 20, ok);
        keys = 16'h0200;  // r2,c1
        wait_row(4'b1011, 20, ok);
        repeat (6) @(negedge clk);
        checks++; if (dbg_state !== DEBOUNCE) begin errors++; $display("FAIL rstdeb_pre_state: got %0d want 1", dbg_state); end
        @(posedge clk);
        #2 rst = 1'b1;
        #1;
        checks++; if (kb_row !== 4'b1110 || key_held !== 1'b0 || key_valid !== 1'b0) begin errors++; $display("FAIL rstdeb_async: row %b held %b valid %b want 1110/0/0", kb_row, key_held, key_valid); end
        checks++; if (dbg_state !== SCAN) begin errors++; $display("FAIL rstdeb_state: got %0d want 0", dbg_state); end
        repeat (2) @(negedge clk);
        rst = 1'b0;
        wait_pulse(80, cyc, ok);
        exp_pulses++;
        checks++; if (!ok || key_code !== 4'd9) begin errors++; $display("FAIL rstdeb_redetect: ok %0d code %0d want 1/9", ok, key_code); end
        checks++; if (key_held !== 1'b1) begin errors++; $display("FAIL rstheld_pre_held: got %b want 1", key_held); end
        @(posedge clk);
        #2 rst = 1'b1;
        #1;
        checks++; if (kb_row !== 4'b1110 || key_held !== 1'b0 || key_code !== 4'd0) begin errors++; $display("FAIL rstheld_async: row %b held %b code %0d want 1110/0/0", kb_row, key_held, key_code); end
        repeat (2) @(negedge clk);
        rst = 1'b0;
        wait_pulse(80, cyc, ok);
        exp_pulses++;
        checks++; if (!ok || key_code !== 4'd9) begin errors++; $display("FAIL rstheld_redetect: ok %0d code %0d want 1/9", ok, key_code); end
        keys = 16'h0000;
        wait_held_low(40, cyc, ok);
        checks++; if (!ok) begin errors++; $display("FAIL rstheld_release: key_held still %b", key_held); end
    endtask

    task automatic test_back_to_back();
        #1;
        checks++; if (double_pulse) begin errors++; $display("FAIL valid_consecutive: key_valid high in two consecutive cycles"); end
        checks++; if (pulse_cnt != exp_pulses) begin errors++; $display("FAIL total_pulses: got %0d want %0d", pulse_cnt, exp_pulses); end
    endtask

    initial begin
        checks       = 0;
        errors       = 0;
        pulse_cnt    = 0;
        exp_pulses   = 0;
        double_pulse = 1'b0;
        prev_valid   = 1'b0;
        rst          = 1'b1;
        keys         = 16'h0000;

        test_reset();
        test_press();
        test_release();
        test_bounce();
        test_multikey();
        test_reset_mid();
        test_back_to_back();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
